// File: rtl/dram_burst_sched.sv
// Burst-level AW/AR scheduler in front of the single-ported mock DRAM: one burst in flight,
// same-direction streak limit while the other direction waits, and burst/beat counters.
module dram_burst_sched #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned ID_W       = 6,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [ID_W-1:0]   aw_id,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [ID_W-1:0]   ar_id,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [ID_W-1:0]   cmd_id,
    input  logic              burst_done,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  wr_bursts,
    output logic [CNT_W-1:0]  rd_bursts,
    output logic [CNT_W-1:0]  wr_beats,
    output logic [CNT_W-1:0]  rd_beats,
    output logic              err_done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam int unsigned      EFF_MAX = (MAX_STREAK == 0) ? 1 : MAX_STREAK;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]        state_q, state_d;
    logic              last_dir_q, last_dir_d;
    logic [3:0]        streak_q, streak_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_len_q, cmd_len_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
    logic [CNT_W-1:0]  wr_bursts_q, wr_bursts_d;
    logic [CNT_W-1:0]  rd_bursts_q, rd_bursts_d;
    logic [CNT_W-1:0]  wr_beats_q, wr_beats_d;
    logic [CNT_W-1:0]  rd_beats_q, rd_beats_d;
    logic              err_done_q, err_done_d;

    logic              streak_ok;
    logic              sel_write;
    logic              grant;
    logic [7:0]        grant_len;

    assign streak_ok = 32'(streak_q) < EFF_MAX;

    // Under contention keep the last direction until its streak reaches the limit.
    always_comb begin
        if (aw_valid && ar_valid) sel_write = streak_ok ? last_dir_q : ~last_dir_q;
        else                      sel_write = aw_valid;
    end

    assign aw_ready  = rst_main_n && (state_q == ST_IDLE) && aw_valid &&  sel_write;
    assign ar_ready  = rst_main_n && (state_q == ST_IDLE) && ar_valid && !sel_write;
    assign grant     = aw_ready | ar_ready;
    assign grant_len = sel_write ? aw_len : ar_len;

    always_comb begin
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        streak_d    = streak_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_id_d    = cmd_id_q;
        wr_bursts_d = wr_bursts_q;
        rd_bursts_d = rd_bursts_q;
        wr_beats_d  = wr_beats_q;
        rd_beats_d  = rd_beats_q;
        err_done_d  = err_done_q | (burst_done && (state_q != ST_BUSY));

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d     = ST_ISSUE;
                    cmd_write_d = sel_write;
                    cmd_addr_d  = sel_write ? aw_addr : ar_addr;
                    cmd_len_d   = grant_len;
                    cmd_id_d    = sel_write ? aw_id : ar_id;
                    if (sel_write == last_dir_q) begin
                        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                    end else begin
                        streak_d   = 4'd1;
                        last_dir_d = sel_write;
                    end
                    if (sel_write) begin
                        wr_bursts_d = wr_bursts_q + CNT_ONE;
                        wr_beats_d  = wr_beats_q + CNT_W'(grant_len) + CNT_ONE;
                    end else begin
                        rd_bursts_d = rd_bursts_q + CNT_ONE;
                        rd_beats_d  = rd_beats_q + CNT_W'(grant_len) + CNT_ONE;
                    end
                end
            end
            ST_ISSUE: if (cmd_ready)  state_d = ST_BUSY;
            ST_BUSY:  if (burst_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Clear overrides a same-cycle grant, which then goes uncounted.
        if (cnt_clear) begin
            wr_bursts_d = '0;
            rd_bursts_d = '0;
            wr_beats_d  = '0;
            rd_beats_d  = '0;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q     <= ST_IDLE;
            last_dir_q  <= 1'b1;
            streak_q    <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_id_q    <= '0;
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
            wr_beats_q  <= '0;
            rd_beats_q  <= '0;
            err_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            streak_q    <= streak_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_id_q    <= cmd_id_d;
            wr_bursts_q <= wr_bursts_d;
            rd_bursts_q <= rd_bursts_d;
            wr_beats_q  <= wr_beats_d;
            rd_beats_q  <= rd_beats_d;
            err_done_q  <= err_done_d;
        end
    end

    assign cmd_valid = (state_q == ST_ISSUE);
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_id    = cmd_id_q;
    assign wr_bursts = wr_bursts_q;
    assign rd_bursts = rd_bursts_q;
    assign wr_beats  = wr_beats_q;
    assign rd_beats  = rd_beats_q;
    assign err_done  = err_done_q;

endmodule

// File: tb/tb_dram_burst_sched.sv
// Bench for dram_burst_sched: cycle vector table, directed corner sequences, and a
// randomized run against a transaction-level model of grant order and counters.
module tb_dram_burst_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        awv, awr, arv, arr, cv, crdy, cw, bd, clr, err;
    logic [63:0] awa, ara, ca;
    logic [7:0]  awl, arl, cl;
    logic [5:0]  awi, ari, ci;
    logic [31:0] wrb, rdb, wrbt, rdbt;

    logic        z_awv, z_awr, z_arv, z_arr, z_cv, z_crdy, z_cw, z_bd, z_clr, z_err;
    logic [63:0] z_awa, z_ara, z_ca;
    logic [7:0]  z_awl, z_arl, z_cl;
    logic [5:0]  z_awi, z_ari, z_ci;
    logic [31:0] z_wrb, z_rdb, z_wrbt, z_rdbt;

    dram_burst_sched #(.ADDR_W(64), .ID_W(6), .MAX_STREAK(4), .CNT_W(32)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .aw_valid(awv), .aw_ready(awr), .aw_addr(awa), .aw_len(awl), .aw_id(awi),
        .ar_valid(arv), .ar_ready(arr), .ar_addr(ara), .ar_len(arl), .ar_id(ari),
        .cmd_valid(cv), .cmd_ready(crdy), .cmd_write(cw), .cmd_addr(ca), .cmd_len(cl), .cmd_id(ci),
        .burst_done(bd), .cnt_clear(clr),
        .wr_bursts(wrb), .rd_bursts(rdb), .wr_beats(wrbt), .rd_beats(rdbt), .err_done(err)
    );

    dram_burst_sched #(.ADDR_W(64), .ID_W(6), .MAX_STREAK(0), .CNT_W(32)) dut_alt (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .aw_valid(z_awv), .aw_ready(z_awr), .aw_addr(z_awa), .aw_len(z_awl), .aw_id(z_awi),
        .ar_valid(z_arv), .ar_ready(z_arr), .ar_addr(z_ara), .ar_len(z_arl), .ar_id(z_ari),
        .cmd_valid(z_cv), .cmd_ready(z_crdy), .cmd_write(z_cw), .cmd_addr(z_ca), .cmd_len(z_cl), .cmd_id(z_ci),
        .burst_done(z_bd), .cnt_clear(z_clr),
        .wr_bursts(z_wrb), .rd_bursts(z_rdb), .wr_beats(z_wrbt), .rd_beats(z_rdbt), .err_done(z_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        awv = 0; arv = 0; crdy = 0; bd = 0; clr = 0;
        z_awv = 0; z_arv = 0; z_crdy = 0; z_bd = 0; z_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_aw_ready"}, awr, 0);
        chk({tag, "_ar_ready"}, arr, 0);
        chk({tag, "_cmd_valid"}, cv, 0);
        chk({tag, "_wr_bursts"}, wrb, 0);
        chk({tag, "_rd_bursts"}, rdb, 0);
        chk({tag, "_wr_beats"}, wrbt, 0);
        chk({tag, "_rd_beats"}, rdbt, 0);
        chk({tag, "_err_done"}, err, 0);
    endtask

    typedef struct {
        bit awv, arv, crdy, bd, clr;
        bit e_awr, e_arr, e_cv, e_cw;
        int unsigned e_wrb, e_wrbt, e_rdb, e_rdbt;
    } vec_t;
    vec_t tbl[15];

    // Reference model state: granted directions, outstanding command, counters.
    bit          m_pend, m_busy, m_err, m_cw;
    bit          m_hist[$];
    logic [63:0] m_ca;
    logic [7:0]  m_cl;
    logic [5:0]  m_ci;
    logic [31:0] m_wrb, m_rdb, m_wrbt, m_rdbt;

    function automatic bit model_sel_write();
        bit last;
        int run;
        if (awv && !arv) return 1'b1;
        if (arv && !awv) return 1'b0;
        if (m_hist.size() == 0) return 1'b1;
        last = m_hist[m_hist.size()-1];
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != last || run >= 15) break;
            run++;
        end
        return (run < 4) ? last : !last;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ord[9];
        bit alt[6];
        bit aw_hs, ar_hs, sw, idle, e_awr, e_arr;

        awa = 64'h1000; awl = 8'd3; awi = 6'd5;
        ara = 64'h2000; arl = 8'd7; ari = 6'd9;
        z_awa = 64'h3000; z_awl = 8'd1; z_awi = 6'd2;
        z_ara = 64'h4000; z_arl = 8'd2; z_ari = 6'd3;

        //                awv arv crdy bd clr awr arr cv cw wrb wrbt rdb rdbt
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 4, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 4, 1, 8};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 1, 8};
        tbl[8]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 4, 1, 8};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 4, 2, 16};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 2, 16};
        tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 2, 16};
        tbl[12] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 8, 2, 16};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 8, 2, 16};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        next();
        rst_n = 1'b1;

        // Vector table
        foreach (tbl[i]) begin
            awv = tbl[i].awv; arv = tbl[i].arv; crdy = tbl[i].crdy; bd = tbl[i].bd; clr = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("tbl%0d_aw_ready", i), awr, tbl[i].e_awr);
            chk($sformatf("tbl%0d_ar_ready", i), arr, tbl[i].e_arr);
            chk($sformatf("tbl%0d_cmd_valid", i), cv, tbl[i].e_cv);
            if (tbl[i].e_cv) begin
                chk($sformatf("tbl%0d_cmd_write", i), cw, tbl[i].e_cw);
                chk($sformatf("tbl%0d_cmd_addr", i), ca, tbl[i].e_cw ? 64'h1000 : 64'h2000);
                chk($sformatf("tbl%0d_cmd_len", i), cl, tbl[i].e_cw ? 8'd3 : 8'd7);
                chk($sformatf("tbl%0d_cmd_id", i), ci, tbl[i].e_cw ? 6'd5 : 6'd9);
            end
            chk($sformatf("tbl%0d_wr_bursts", i), wrb, tbl[i].e_wrb);
            chk($sformatf("tbl%0d_wr_beats", i), wrbt, tbl[i].e_wrbt);
            chk($sformatf("tbl%0d_rd_bursts", i), rdb, tbl[i].e_rdb);
            chk($sformatf("tbl%0d_rd_beats", i), rdbt, tbl[i].e_rdbt);
            chk($sformatf("tbl%0d_err_done", i), err, 0);
            next();
        end

        // Contention with streak limit 4, writes first after reset
        do_reset();
        ord = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        awv = 1; arv = 1; crdy = 1;
        for (int g = 0; g < 9; g++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_aw_ready", g), awr, ord[g]);
            chk($sformatf("cont%0d_ar_ready", g), arr, !ord[g]);
            next();
            @(negedge clk);
            chk($sformatf("cont%0d_issue_readies", g), {awr, arr}, 2'b00);
            chk($sformatf("cont%0d_cmd_write", g), cw, ord[g]);
            next();
            bd = 1;
            next();
            bd = 0;
        end

        // cmd_ready stall: fields stable, no second grant
        awv = 1; arv = 0; crdy = 0;
        @(negedge clk);
        chk("stall_grant", awr, 1);
        next();
        arv = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_cmd_valid", k), cv, 1);
            chk($sformatf("stall%0d_fields", k), {cw, ca[31:0], cl, ci}, {1'b1, 32'h1000, 8'd3, 6'd5});
            chk($sformatf("stall%0d_readies", k), {awr, arr}, 2'b00);
            chk($sformatf("stall%0d_wr_bursts", k), wrb, 6);
            next();
        end
        awv = 0; arv = 0; crdy = 1;
        next();
        bd = 1;
        next();
        bd = 0;

        // burst_done while idle sets sticky error; a read still completes
        bd = 1;
        next();
        bd = 0;
        arv = 1;
        @(negedge clk);
        chk("idle_done_err", err, 1);
        chk("idle_done_ar_ready", arr, 1);
        next();
        arv = 0; crdy = 1;
        @(negedge clk);
        chk("idle_done_cmd", {cv, cw, ca}, {1'b1, 1'b0, 64'h2000});
        next();
        bd = 1;
        next();
        bd = 0;
        @(negedge clk);
        chk("idle_done_rd_bursts", rdb, 5);
        chk("idle_done_rd_beats", rdbt, 40);
        chk("idle_done_err_sticky", err, 1);
        next();

        // Reset asserted while busy
        awv = 1; crdy = 1;
        next();
        awv = 0;
        next();
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_busy");
        next();
        arv = 1;
        @(negedge clk);
        chk("rst_hold_ar_ready", arr, 0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ar_ready", arr, 1);
        chk("rst_rel_cmd_valid", cv, 0);
        chk("rst_rel_err", err, 0);
        next();
        arv = 0;
        @(negedge clk);
        chk("rst_rel_cmd", {cv, cw, ca}, {1'b1, 1'b0, 64'h2000});
        chk("rst_rel_rd_bursts", rdb, 1);
        next();
        bd = 1;
        next();
        bd = 0;

        // cnt_clear coincident with a grant
        arv = 1; clr = 1;
        @(negedge clk);
        chk("clr_grant_ar_ready", arr, 1);
        next();
        arv = 0; clr = 0;
        @(negedge clk);
        chk("clr_grant_rd_bursts", rdb, 0);
        chk("clr_grant_rd_beats", rdbt, 0);
        chk("clr_grant_cmd_valid", cv, 1);
        next();
        bd = 1;
        next();
        bd = 0;

        // MAX_STREAK=0: strict alternation
        do_reset();
        alt = '{1, 0, 1, 0, 1, 0};
        z_awv = 1; z_arv = 1; z_crdy = 1; z_bd = 1;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_aw_ready", g), z_awr, alt[g]);
            chk($sformatf("alt%0d_ar_ready", g), z_arr, !alt[g]);
            next();
            @(negedge clk);
            chk($sformatf("alt%0d_cmd", g), {z_cv, z_cw, z_ca, z_cl, z_ci},
                alt[g] ? {1'b1, 1'b1, 64'h3000, 8'd1, 6'd2} : {1'b1, 1'b0, 64'h4000, 8'd2, 6'd3});
            next();
            next();
        end
        z_awv = 0; z_arv = 0; z_bd = 0;
        @(negedge clk);
        chk("alt_counts", {z_wrb, z_wrbt, z_rdb, z_rdbt}, {32'd3, 32'd6, 32'd3, 32'd9});
        chk("alt_err", z_err, 1);
        chk("alt_clr_idle", z_clr, 0);
        next();

        // Randomized run against the reference model
        do_reset();
        m_pend = 0; m_busy = 0; m_err = 0;
        m_hist.delete();
        m_wrb = 0; m_rdb = 0; m_wrbt = 0; m_rdbt = 0;
        aw_hs = 0; ar_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            if (aw_hs) awv = 0;
            if (ar_hs) arv = 0;
            if (!awv && $urandom_range(0, 2) == 0) begin
                awv = 1; awa = {$urandom, $urandom}; awl = 8'($urandom); awi = 6'($urandom);
            end
            if (!arv && $urandom_range(0, 2) == 0) begin
                arv = 1; ara = {$urandom, $urandom}; arl = 8'($urandom); ari = 6'($urandom);
            end
            crdy = 1'($urandom_range(0, 1));
            bd = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            sw = model_sel_write();
            idle = !m_pend && !m_busy;
            e_awr = idle && awv && sw;
            e_arr = idle && arv && !sw;
            chk("rnd_aw_ready", awr, e_awr);
            chk("rnd_ar_ready", arr, e_arr);
            chk("rnd_cmd_valid", cv, m_pend);
            if (m_pend) chk("rnd_cmd_fields", {cw, ca, cl, ci}, {m_cw, m_ca, m_cl, m_ci});
            chk("rnd_counters", {wrb, rdb}, {m_wrb, m_rdb});
            chk("rnd_beats", {wrbt, rdbt}, {m_wrbt, m_rdbt});
            chk("rnd_err_done", err, m_err);
            if (bd && !m_busy) m_err = 1;
            if (m_busy && bd) m_busy = 0;
            if (m_pend && crdy) begin m_pend = 0; m_busy = 1; end
            if (e_awr || e_arr) begin
                m_pend = 1;
                m_cw = e_awr;
                m_ca = e_awr ? awa : ara;
                m_cl = e_awr ? awl : arl;
                m_ci = e_awr ? awi : ari;
                m_hist.push_back(e_awr);
                if (m_hist.size() > 32) void'(m_hist.pop_front());
                if (e_awr) begin m_wrb = m_wrb + 1; m_wrbt = m_wrbt + 32'(awl) + 32'd1; end
                else       begin m_rdb = m_rdb + 1; m_rdbt = m_rdbt + 32'(arl) + 32'd1; end
            end
            if (clr) begin m_wrb = 0; m_rdb = 0; m_wrbt = 0; m_rdbt = 0; end
            aw_hs = e_awr;
            ar_hs = e_arr;
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
